// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: sync byte, widths and state encoding.
package prog_loader_pkg;

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         ADDR_W = 16;
    localparam int         DATA_W = 16;

    // Encodings follow the frame field order: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, {D_H, D_L}*, CHK.
    localparam logic [3:0] ENC_IDLE   = 4'd0;
    localparam logic [3:0] ENC_ADDR_H = 4'd1;
    localparam logic [3:0] ENC_ADDR_L = 4'd2;
    localparam logic [3:0] ENC_CNT_H  = 4'd3;
    localparam logic [3:0] ENC_CNT_L  = 4'd4;
    localparam logic [3:0] ENC_DATA_H = 4'd5;
    localparam logic [3:0] ENC_DATA_L = 4'd6;
    localparam logic [3:0] ENC_WRITE  = 4'd7;
    localparam logic [3:0] ENC_CHK    = 4'd8;
    localparam logic [3:0] ENC_DONE   = 4'd9;
    localparam logic [3:0] ENC_ERR    = 4'd10;

    typedef enum logic [3:0] {
        StIdle  = ENC_IDLE,
        StAddrH = ENC_ADDR_H,
        StAddrL = ENC_ADDR_L,
        StCntH  = ENC_CNT_H,
        StCntL  = ENC_CNT_L,
        StDataH = ENC_DATA_H,
        StDataL = ENC_DATA_L,
        StWrite = ENC_WRITE,
        StChk   = ENC_CHK,
        StDone  = ENC_DONE,
        StErr   = ENC_ERR
    } state_t;

    function automatic logic is_frame_state(state_t s);
        return !(s inside {StIdle, StDone, StErr});
    endfunction

endpackage

// File: rtl/prog_loader_fsm.sv
// Frame parser and checksum: turns the byte stream into registered RAM word writes.
module prog_loader_fsm
    import prog_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_wr_stb,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_word,
    output logic              o_done,
    output logic              o_bad,
    output logic              o_busy
);

    state_t            r_state, w_state_next;
    logic [7:0]        r_sum, w_sum_next;
    logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_next;
    logic [15:0]       r_cnt, w_cnt_next;
    logic [7:0]        r_dh, w_dh_next;
    logic              r_wr_stb, w_wr_stb_next;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next;
    logic [DATA_W-1:0] r_wr_word, w_wr_word_next;
    logic              r_rx_ready, w_rx_ready_next;
    logic              w_xfer;
    logic [7:0]        w_sum_add;

    assign w_xfer    = i_rx_valid & r_rx_ready;
    assign w_sum_add = r_sum + i_rx_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_sum      <= 8'h00;
            r_cur_addr <= '0;
            r_cnt      <= 16'h0000;
            r_dh       <= 8'h00;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_word  <= '0;
            r_rx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sum      <= w_sum_next;
            r_cur_addr <= w_cur_addr_next;
            r_cnt      <= w_cnt_next;
            r_dh       <= w_dh_next;
            r_wr_stb   <= w_wr_stb_next;
            r_wr_addr  <= w_wr_addr_next;
            r_wr_word  <= w_wr_word_next;
            r_rx_ready <= w_rx_ready_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_sum_next      = r_sum;
        w_cur_addr_next = r_cur_addr;
        w_cnt_next      = r_cnt;
        w_dh_next       = r_dh;
        w_wr_stb_next   = 1'b0;
        w_wr_addr_next  = r_wr_addr;
        w_wr_word_next  = r_wr_word;

        // Header and payload bytes all feed the running checksum.
        if (w_xfer && (r_state inside {StAddrH, StAddrL, StCntH, StCntL, StDataH, StDataL})) begin
            w_sum_next = w_sum_add;
        end

        case (r_state)
            StIdle, StErr: begin
                if (w_xfer && i_rx_data == SYNC) begin
                    w_state_next = StAddrH;
                    w_sum_next   = 8'h00;
                end
            end
            StAddrH: if (w_xfer) begin
                w_cur_addr_next[15:8] = i_rx_data;
                w_state_next          = StAddrL;
            end
            StAddrL: if (w_xfer) begin
                w_cur_addr_next[7:0] = i_rx_data;
                w_state_next         = StCntH;
            end
            StCntH: if (w_xfer) begin
                w_cnt_next[15:8] = i_rx_data;
                w_state_next     = StCntL;
            end
            StCntL: if (w_xfer) begin
                w_cnt_next   = {r_cnt[15:8], i_rx_data};
                w_state_next = ({r_cnt[15:8], i_rx_data} == 16'h0000) ? StChk : StDataH;
            end
            StDataH: if (w_xfer) begin
                w_dh_next    = i_rx_data;
                w_state_next = StDataL;
            end
            StDataL: if (w_xfer) begin
                w_wr_stb_next  = 1'b1;
                w_wr_addr_next = r_cur_addr;
                w_wr_word_next = {r_dh, i_rx_data};
                w_state_next   = StWrite;
            end
            StWrite: begin
                w_cur_addr_next = r_cur_addr + 1'b1;
                w_cnt_next      = r_cnt - 16'd1;
                w_state_next    = (r_cnt == 16'd1) ? StChk : StDataH;
            end
            StChk: if (w_xfer) begin
                w_state_next = (w_sum_add == 8'h00) ? StDone : StErr;
            end
            StDone: w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase

        w_rx_ready_next = !(w_state_next inside {StWrite, StDone});
    end

    assign o_rx_ready = r_rx_ready;
    assign o_wr_stb   = r_wr_stb;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_word  = r_wr_word;
    assign o_done     = (r_state == StDone);
    assign o_bad      = (r_state == StErr);
    assign o_busy     = is_frame_state(r_state);

endmodule

// File: rtl/prog_loader.sv
// Boot loader top: frame parser plus the RAM port mux that hands memory to the core once loaded.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_din,
    input  logic              i_cpu_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    output logic              o_mem_we,
    output logic              o_cpu_run,
    output logic              o_busy,
    output logic              o_err
);

    logic              w_wr_stb;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_word;
    logic              w_done;
    logic              w_bad;

    prog_loader_fsm u_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_wr_stb   (w_wr_stb),
        .o_wr_addr  (w_wr_addr),
        .o_wr_word  (w_wr_word),
        .o_done     (w_done),
        .o_bad      (w_bad),
        .o_busy     (o_busy)
    );

    assign o_cpu_run = w_done;
    assign o_err     = w_bad;

    // Core writes are blocked until the loaded image has been verified.
    assign o_mem_addr = w_done ? i_cpu_addr : w_wr_addr;
    assign o_mem_din  = w_done ? i_cpu_din  : w_wr_word;
    assign o_mem_we   = w_done ? i_cpu_we   : w_wr_stb;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level model of expected writes plus per-cycle port checks.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] cpu_addr = 16'h0000;
    logic [15:0] cpu_din = 16'h0000;
    logic        cpu_we = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        cpu_run;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:65535];
    logic [7:0]  frame_q [$];
    logic [31:0] exp_q [$];
    logic        prev_rst = 1'b0;

    prog_loader dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_rx_ready (rx_ready),
        .i_cpu_addr (cpu_addr),
        .i_cpu_din  (cpu_din),
        .i_cpu_we   (cpu_we),
        .o_mem_addr (mem_addr),
        .o_mem_din  (mem_din),
        .o_mem_we   (mem_we),
        .o_cpu_run  (cpu_run),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Word RAM downstream of the loader.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        prev_rst <= rst_n;
    end

    // Core traffic is random all the time; it must only reach RAM once the core runs.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cpu_addr = 16'($urandom);
            cpu_din  = 16'($urandom);
            cpu_we   = 1'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the frame model and the port-ownership rules.
    always @(negedge clk) begin
        logic [31:0] e;
        if (prev_rst) begin
            if (cpu_run) begin
                check("mux_addr", {16'h0, mem_addr}, {16'h0, cpu_addr});
                check("mux_din", {16'h0, mem_din}, {16'h0, cpu_din});
                check("mux_we", {31'h0, mem_we}, {31'h0, cpu_we});
                check("ready_in_done", {31'h0, rx_ready}, 32'h0);
            end else begin
                check("ready_vs_write", {31'h0, rx_ready}, {31'h0, !mem_we});
                if (mem_we) begin
                    check("we_pending", {31'h0, exp_q.size() != 0}, 32'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", {16'h0, mem_addr}, {16'h0, e[31:16]});
                        check("wr_data", {16'h0, mem_din}, {16'h0, e[15:0]});
                    end
                end
            end
        end
    end

    // Frame semantics: payload words land at consecutive wrapping addresses; sum after SYNC is 0.
    task automatic model_frame(output bit good);
        logic [7:0]  s;
        logic [15:0] a;
        logic [15:0] c;
        s = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) s += frame_q[i];
        a = {frame_q[1], frame_q[2]};
        c = {frame_q[3], frame_q[4]};
        for (int k = 0; k < int'(c); k++)
            exp_q.push_back({a + 16'(k), frame_q[5 + 2 * k], frame_q[6 + 2 * k]});
        good = (s == 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            errors++;
            $display("FAIL handshake_timeout: byte %0h never accepted", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        bit good;
        int n;
        model_frame(good);
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            send_byte(frame_q[i], $urandom_range(0, maxgap));
            if (i == 0) check("busy_after_sync", {31'h0, busy}, 32'h1);
        end
        check("cpu_run_end", {31'h0, cpu_run}, {31'h0, good});
        check("err_end", {31'h0, err}, {31'h0, !good});
        check("busy_end", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        check("writes_drained", exp_q.size(), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_cpu_run", {31'h0, cpu_run}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        check("rst_mem_din", {16'h0, mem_din}, 32'h0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'h0, rx_ready}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        // 1: basic two-word frame
        do_reset();
        send_byte(8'h3C, 0);
        frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h05, 8'hD6};
        send_frame(0);
        check("t1_m32", {16'h0, mem[32]}, 32'h3);
        check("t1_m33", {16'h0, mem[33]}, 32'h5);
        check("t1_run", {31'h0, cpu_run}, 32'h1);
        repeat (5) @(negedge clk);

        // 2: zero count
        do_reset();
        frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
        send_frame(1);
        check("t2_run", {31'h0, cpu_run}, 32'h1);

        // 3: address wrap
        do_reset();
        frame_q = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFD};
        send_frame(0);
        check("t3_mffff", {16'h0, mem[16'hFFFF]}, 32'h1);
        check("t3_m0", {16'h0, mem[0]}, 32'h2);

        // 4: bad checksum, junk, then good frame
        do_reset();
        frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h05, 8'hD7};
        send_frame(1);
        check("t4_err", {31'h0, err}, 32'h1);
        check("t4_run", {31'h0, cpu_run}, 32'h0);
        send_byte(8'h12, 0);
        send_byte(8'h5A, 2);
        check("t4_err_hold", {31'h0, err}, 32'h1);
        frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h05, 8'hD6};
        send_frame(0);
        check("t4_err_clear", {31'h0, err}, 32'h0);

        // 5: random gaps, then core traffic through the mux
        do_reset();
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78,
                    8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC3};
        send_frame(4);
        check("t5_m100", {16'h0, mem[16'h0100]}, 32'h1234);
        check("t5_m103", {16'h0, mem[16'h0103]}, 32'hDEF0);
        repeat (20) @(negedge clk);

        // 6: reset in the middle of a frame
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        check("t6_busy", {31'h0, busy}, 32'h1);
        do_reset();
        repeat (3) @(negedge clk);
        check("t6_idle_run", {31'h0, cpu_run}, 32'h0);
        frame_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h05, 8'hD6};
        send_frame(2);
        check("t6_run", {31'h0, cpu_run}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
